switch_debouncer: RTL and testbench

Debounces one mechanical push-button for the Frogger board design. The raw pin is synchronised into the `i_Clk` domain, and the output changes only after the input has held a new level for `DEBOUNCE_LIMIT` consecutive clocks. One instance sits on each of the four direction switches feeding the frog-movement logic. One-cycle press/release pulses are also provided, so consumers need no edge detector of their own.

---
 rtl/frogger_pkg.sv | 13 +
 rtl/sync_2ff.sv | 23 ++
 rtl/switch_debouncer.sv | 64 ++++++
 tb/tb_switch_debouncer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Board-wide constants and small shared types for the Frogger design.
package frogger_pkg;

  localparam int unsigned CLK_FREQ_HZ            = 25_000_000;
  localparam int unsigned DEBOUNCE_MS            = 10;
  localparam int unsigned DEBOUNCE_LIMIT_DEFAULT = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

  typedef struct packed {
    logic rise;
    logic fall;
  } sw_edge_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/switch_debouncer.sv
// Push-button debouncer: output follows the synchronised pin only after it has
// held a new level for DEBOUNCE_LIMIT clocks; one-cycle rise/fall pulses included.
module switch_debouncer
  import frogger_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
  parameter int unsigned CNT_W          = $clog2(DEBOUNCE_LIMIT)
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Switch_state,
  output logic o_Rise,
  output logic o_Fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sw_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  sw_edge_t         edge_q, edge_d;

  sync_2ff u_sync (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_n),
    .d_i    (i_Switch),
    .q_o    (sw_s)
  );

  // Any sample agreeing with the current output restarts the count, so a
  // bounce never accumulates credit toward a change.
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    edge_d  = '0;
    if (sw_s != state_q) begin
      if (cnt_q == CNT_MAX) begin
        state_d     = sw_s;
        edge_d.rise = sw_s;
        edge_d.fall = ~sw_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      edge_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      edge_q  <= edge_d;
    end
  end

  assign o_Switch_state = state_q;
  assign o_Rise         = edge_q.rise;
  assign o_Fall         = edge_q.fall;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised + directed bench for switch_debouncer with DEBOUNCE_LIMIT=4.
module tb_switch_debouncer;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;
  logic st, rise, fall;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: input history since reset, derived synchronised samples
  bit in_q[$];
  bit s_q[$];
  bit m_state, m_rise, m_fall;
  int rise_cnt = 0;
  int fall_cnt = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.DEBOUNCE_LIMIT(LIM)) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Switch       (sw),
    .o_Switch_state (st),
    .o_Rise         (rise),
    .o_Fall         (fall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_q.delete();
    s_q.delete();
    m_state = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
  endtask

  // The logic sees the pin value from two edges earlier (0 if not yet seen
  // since reset). The output flips once the last LIM such samples all differ from it.
  task automatic model_edge(input bit v);
    bit s, all_diff;
    in_q.push_back(v);
    s = (in_q.size() >= 3) ? in_q[in_q.size()-3] : 1'b0;
    s_q.push_back(s);
    if (in_q.size() > 8) void'(in_q.pop_front());
    if (s_q.size() > 8) void'(s_q.pop_front());
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s_q.size() >= LIM) begin
      all_diff = 1'b1;
      for (int j = 1; j <= LIM; j++)
        if (s_q[s_q.size()-j] == m_state) all_diff = 1'b0;
      if (all_diff) begin
        m_state = ~m_state;
        m_rise  = m_state;
        m_fall  = ~m_state;
      end
    end
  endtask

  // Drive v for the next edge, advance one clock, then compare 1 ns later.
  task automatic tick(input bit v);
    sw = v;
    @(posedge clk);
    if (rst_n) model_edge(v);
    #1;
    chk("state", st, m_state);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("rise_fall_excl", rise & fall, 1'b0);
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
  endtask

  task automatic do_reset(input bit v, input int cycles);
    sw = v;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_state", st, 1'b0);
    chk("rst_rise", rise, 1'b0);
    chk("rst_fall", fall, 1'b0);
    for (int i = 0; i < cycles; i++) tick(v);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx, r0, f0, hold;
    bit v;

    // power-on reset with the switch pressed
    sw = 1'b1;
    #2;
    do_reset(1'b1, 3);
    for (int i = 0; i < 10; i++) tick(1'b0);
    chk("idle_state", st, 1'b0);

    // clean press: change before edge k, update after edge k+5
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      if (i == 4) chk("press_early", st, 1'b0);
      if (rise && idx < 0) idx = i;
      if (i == 6) chk("press_pulse_end", rise, 1'b0);
    end
    chk("press_lat", idx, 5);
    chk("press_state", st, 1'b1);

    // release from 1
    f0 = fall_cnt;
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      if (fall && idx < 0) idx = i;
    end
    chk("release_lat", idx, 5);
    chk("release_cnt", fall_cnt - f0, 1);
    chk("release_state", st, 1'b0);

    // bounce: 3 high, 1 low, 3 high, low
    r0 = rise_cnt;
    for (int i = 0; i < 3; i++) tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    chk("bounce_rise", rise_cnt - r0, 0);
    chk("bounce_state", st, 1'b0);

    // reset two clocks into a count, input still high after release
    tick(1'b1);
    tick(1'b1);
    do_reset(1'b1, 2);
    idx = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      if (rise && idx < 0) idx = i;
    end
    chk("midrst_lat", idx, 6);
    for (int i = 0; i < 10; i++) tick(1'b0);

    // long hold
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 1000; i++) tick(1'b1);
    chk("hold_rise", rise_cnt - r0, 1);
    chk("hold_fall", fall_cnt - f0, 0);
    chk("hold_state", st, 1'b1);

    // random segments with occasional asynchronous resets
    for (int n = 0; n < 600; n++) begin
      v = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        do_reset(v, $urandom_range(0, 3));
      end
      for (int i = 0; i < hold; i++) tick(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
